io_rx_fifo: RTL

Byte-wide receive FIFO peripheral on the RISCuva1 I/O port bus, directly downstream of the core's port interface. External logic (UART receiver, sensor front-end) pushes bytes with a valid/ready handshake. The core drains them with port reads and can configure, flush and check status through port writes and reads. The block raises the core's level-sensitive `intReq` when the enabled fill level reaches a watermark.

---
 rtl/io_port_pkg.sv | 41 ++++
 rtl/io_byte_fifo.sv | 72 +++++++
 rtl/io_rx_fifo.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/io_port_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// io_port_pkg
// Shared definitions for peripherals on the RISCuva1 I/O port bus:
// register offsets inside a peripheral's 4-address window, status and control
// bit positions, a packed status layout and a watermark helper.
// -----------------------------------------------------------------------------
package io_port_pkg;

    // Register offsets (portAddress[1:0]) inside the peripheral window.
    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_WM   = 2'd2;

    // Status register bit positions.
    localparam int STAT_OVF     = 7;
    localparam int STAT_UNF     = 6;
    localparam int STAT_IE      = 5;
    localparam int STAT_FULL    = 4;
    localparam int STAT_CNT_LSB = 0;

    // Control register bit positions.
    localparam int CTL_IE    = 0;
    localparam int CTL_FLUSH = 1;
    localparam int CTL_CLR   = 7;

    // Status byte as seen by the core; field order matches the bit positions.
    typedef struct packed {
        logic       ovf;
        logic       unf;
        logic       ie;
        logic       full;
        logic [3:0] count;
    } status_t;

    // A programmed watermark of 0 behaves like 1.
    function automatic logic [3:0] effective_wm(input logic [3:0] wm);
        return (wm == 4'd0) ? 4'd1 : wm;
    endfunction

endpackage

// File: rtl/io_byte_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// io_byte_fifo
// Byte FIFO storage with wrapping pointers, an occupancy count and an
// asynchronous head read. Push is ignored when full, pop when empty, and
// flush overrides both in the same cycle.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   push, push_data write push_data at the write pointer (if not full)
//   pop             advance the read pointer (if not empty)
//   flush           empty the FIFO, pointers back to 0
//   head            byte at the read pointer (stale when empty)
//   count           occupancy 0..DEPTH
//   full, empty     occupancy flags
// -----------------------------------------------------------------------------
module io_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    input  logic       flush,
    output logic [7:0] head,
    output logic [3:0] count,
    output logic       full,
    output logic       empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == 4'(DEPTH));
    assign empty   = (count == 4'd0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign head    = mem[rd_ptr];

    // NOTE: the storage array is deliberately left out of reset; count and
    // pointers define which entries are valid, so resetting data adds nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            // Power-of-two depth: pointers wrap naturally modulo DEPTH.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_rx_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// io_rx_fifo
// Byte-wide receive FIFO peripheral on the RISCuva1 I/O port bus. A producer
// pushes bytes through a valid/ready handshake; the core pops them by reading
// offset +0, reads status at +1, writes control at +1 and (optionally) the
// interrupt watermark at +2. intReq is a registered level request.
//
// Optional feature macro: IO_RX_FIFO_WATERMARK_EN
//   defined     - +2 register exists, intReq = ie & (count >= wm)
//   not defined - wm fixed at 1,      intReq = ie & ~empty
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   portAddress  core port address; window is BASE_ADDR..BASE_ADDR+3
//   portRead     core read strobe (a read of +0 pops)
//   portWrite    core write strobe
//   wrData       core write data
//   rdData       read data, 8'h00 when not selected (OR-combined bus)
//   intReq       level interrupt request
//   in_valid     producer has a byte
//   in_data      producer byte
//   in_ready     FIFO can accept (= ~full)
// -----------------------------------------------------------------------------
module io_rx_fifo
    import io_port_pkg::*;
#(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] BASE_ADDR = 8'hE0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] portAddress,
    input  logic       portRead,
    input  logic       portWrite,
    input  logic [7:0] wrData,
    output logic [7:0] rdData,
    output logic       intReq,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready
);
    logic       sel;
    logic [1:0] offset;
    logic       rd_data;
    logic       wr_ctl;
    logic       flush;
    logic       clr;
    logic       pop;
    logic       drop;
    logic       underflow;

    logic [7:0] head;
    logic [3:0] count;
    logic       full;
    logic       empty;

    logic       ovf;
    logic       unf;
    logic       ie;
    logic       level;
    status_t    status;
    logic       unused_wr_bits;

    // Window decode: BASE_ADDR is a multiple of 4, so the upper six bits
    // select the block and the lower two bits pick the register.
    assign sel       = (portAddress[7:2] == BASE_ADDR[7:2]);
    assign offset    = portAddress[1:0];
    assign rd_data   = portRead  & sel & (offset == REG_DATA);
    assign wr_ctl    = portWrite & sel & (offset == REG_STAT);
    assign flush     = wr_ctl & wrData[CTL_FLUSH];
    assign clr       = wr_ctl & wrData[CTL_CLR];

    // Pop is attempted on every data read; an empty read flags underflow.
    assign pop       = rd_data;
    assign underflow = rd_data & empty;
    // A byte offered while full is lost, unless a flush discards it anyway.
    assign drop      = in_valid & full & ~flush;
    assign in_ready  = ~full;

    // Control bits 6:2 are reserved.
    assign unused_wr_bits = ^wrData[6:2];

    io_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Sticky error flags: a new event in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
            ie  <= 1'b0;
        end else begin
            if (clr)       ovf <= 1'b0;
            if (clr)       unf <= 1'b0;
            if (drop)      ovf <= 1'b1;
            if (underflow) unf <= 1'b1;
            if (wr_ctl)    ie  <= wrData[CTL_IE];
        end
    end

`ifdef IO_RX_FIFO_WATERMARK_EN
    logic       wr_wm;
    logic [3:0] wm;

    assign wr_wm = portWrite & sel & (offset == REG_WM);

    always_ff @(posedge clk) begin
        if (reset) begin
            wm <= 4'd1;
        end else if (wr_wm) begin
            wm <= wrData[3:0];
        end
    end

    // Watermarks above DEPTH can never be reached by count.
    assign level = (count >= effective_wm(wm));
`else
    assign level = ~empty;
`endif

    // Registered so intReq follows count/ie by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            intReq <= 1'b0;
        end else begin
            intReq <= ie & level;
        end
    end

    always_comb begin
        status.ovf   = ovf;
        status.unf   = unf;
        status.ie    = ie;
        status.full  = full;
        status.count = count;
    end

    // Combinational read path: the core captures dataIn on the same edge
    // that pops the head byte.
    always_comb begin
        // NOTE: default first, so every path through the block assigns
        // rdData and no latch is inferred.
        rdData = 8'h00;
        if (portRead && sel) begin
            case (offset)
                REG_DATA: rdData = empty ? 8'h00 : head;
                REG_STAT: rdData = status;
                default:  rdData = 8'h00;
            endcase
        end
    end

endmodule
